add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq.sv | 131 +++++++++++++
 tb/tb_add_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq.sv
// Sequential adder/subtractor: adds SLICE bits per clock, LSB first, and
// publishes {co, s, ovf} together with a one-cycle done pulse.
module add_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d, ovf_q, ovf_d;

   logic [SLICE-1:0] sl_a, sl_b;
   logic [SLICE:0]   sl_sum;
   logic [WIDTH-1:0] part_nx;
   logic             last;

   // Slice datapath: select the current slice, add it, and splice the result
   // into a copy of the partial register.
   always_comb begin
      sl_a    = '0;
      sl_b    = '0;
      part_nx = part_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) begin
            sl_a = a_q[i*SLICE +: SLICE];
            sl_b = b_q[i*SLICE +: SLICE];
         end
      end
      sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE{1'b0}}, carry_q};
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) part_nx[i*SLICE +: SLICE] = sl_sum[SLICE-1:0];
      end
      last = (cnt_q == CW'(NSLICE - 1));
   end

   always_comb begin
      // NOTE: every signal gets a default here so no path through the case
      // leaves one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      part_d  = part_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      case (state_q)
         RUN: begin
            part_d  = part_nx;
            carry_d = sl_sum[SLICE];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               s_d     = part_nx;
               co_d    = sl_sum[SLICE];
               // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
               ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ part_nx[WIDTH-1] ^ sl_sum[SLICE];
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : ci;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // values from before the edge; operand and partial registers are cleared
   // on reset too, so nothing in the block starts out unknown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         part_q  <= part_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed table, multi-cycle corner cases,
// and randomised scoreboard runs at SLICE = 4, 1 and 16.
module tb_add_seq;

   localparam int W   = 16;
   localparam int NS4 = 4;

   typedef struct packed {
      logic         co;
      logic [W-1:0] s;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic         sub;
      res_t         exp;
   } vec_t;

   logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, ci = 1'b0, sub = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic [W-1:0] s4, s1, s16;
   logic         co4, co1, co16, ovf4, ovf1, ovf16;
   logic         busy4, busy1, busy16, done4, done1, done16;

   int           errors = 0;
   int           checks = 0;
   res_t         exp4[$], exp1[$], exp16[$];
   bit           chk_all = 1'b0;
   logic [W-1:0] last_s = '0;
   vec_t         tbl[10];

   add_seq #(.WIDTH(W), .SLICE(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
      .s(s4), .co(co4), .ovf(ovf4), .busy(busy4), .done(done4));

   add_seq #(.WIDTH(W), .SLICE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
      .s(s1), .co(co1), .ovf(ovf1), .busy(busy1), .done(done1));

   add_seq #(.WIDTH(W), .SLICE(16)) u_s16 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
      .s(s16), .co(co16), .ovf(ovf16), .busy(busy16), .done(done16));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mci, input logic msub);
      logic [W-1:0] bb;
      logic [W:0]   t;
      res_t         r;
      bb    = msub ? ~mb : mb;
      t     = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mci)};
      r.s   = t[W-1:0];
      r.co  = t[W];
      r.ovf = (ma[W-1] == bb[W-1]) && (r.s[W-1] != ma[W-1]);
      return r;
   endfunction

   task automatic set_vec(input int i, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vci, input logic vsub,
                          input logic eco, input logic [W-1:0] es, input logic eovf);
      tbl[i].a       = va;
      tbl[i].b       = vb;
      tbl[i].ci      = vci;
      tbl[i].sub     = vsub;
      tbl[i].exp.co  = eco;
      tbl[i].exp.s   = es;
      tbl[i].exp.ovf = eovf;
   endtask

   task automatic drive_rand(output res_t r);
      a     = W'($urandom);
      b     = W'($urandom);
      ci    = 1'($urandom);
      sub   = 1'($urandom);
      start = 1'b1;
      r     = model(a, b, ci, sub);
   endtask

   // One isolated operation: latency, busy, output hold and operand isolation.
   task automatic run_op(input vec_t v);
      @(negedge clk);
      a = v.a; b = v.b; ci = v.ci; sub = v.sub; start = 1'b1;
      exp4.push_back(v.exp);
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      for (int i = 0; i < NS4; i++) begin
         @(negedge clk);
         check("busy_run", 32'(busy4), 32'd1);
         check("done_run", 32'(done4), 32'd0);
         check("s_hold", 32'(s4), 32'(last_s));
      end
      @(negedge clk);
      check("done_pulse", 32'(done4), 32'd1);
      check("busy_done", 32'(busy4), 32'd0);
      @(negedge clk);
      check("done_clear", 32'(done4), 32'd0);
      check("s_after", 32'(s4), 32'(v.exp.s));
      last_s = v.exp.s;
   endtask

   // Scoreboard monitor: compare every completion against the queued model value.
   always @(negedge clk) begin : monitor
      res_t r;
      if (rst_n) begin
         if (done4) begin
            if (exp4.size() == 0) fail("res4_unexpected_done");
            else begin
               r = exp4.pop_front();
               check("res4", 32'({co4, s4, ovf4}), 32'(r));
            end
         end
         if (chk_all && done1) begin
            if (exp1.size() == 0) fail("res1_unexpected_done");
            else begin
               r = exp1.pop_front();
               check("res1", 32'({co1, s1, ovf1}), 32'(r));
            end
         end
         if (chk_all && done16) begin
            if (exp16.size() == 0) fail("res16_unexpected_done");
            else begin
               r = exp16.pop_front();
               check("res16", 32'({co16, s16, ovf16}), 32'(r));
            end
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      res_t r;
      vec_t v;
      int   k;

      set_vec(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0);
      set_vec(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
      set_vec(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1);
      set_vec(3, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1);
      set_vec(4, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
      set_vec(5, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0);
      set_vec(6, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      set_vec(7, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      set_vec(8, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
      set_vec(9, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0);

      // Reset state, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("rst_s", 32'(s4), 32'd0);
      check("rst_flags", 32'({co4, ovf4, busy4, done4}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) run_op(tbl[i]);

      // start held high with changing operands during RUN.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
      exp4.push_back(model(16'h1234, 16'h1111, 1'b0, 1'b0));
      for (int i = 0; i < NS4 - 1; i++) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
         check("busy_start_in_run", 32'(busy4), 32'd1);
      end
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("done_start_in_run", 32'(done4), 32'd1);

      // Back-to-back: start in the DONE cycle.
      a = 16'h00FF; b = 16'h0001; ci = 1'b0; sub = 1'b0; start = 1'b1;
      exp4.push_back(model(16'h00FF, 16'h0001, 1'b0, 1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!done4 && k < 20);
      check("b2b_latency", 32'(k), 32'd5);

      // Reset in the second RUN cycle aborts with no done pulse.
      @(negedge clk);
      a = 16'h7FFF; b = 16'h0001; ci = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_s", 32'(s4), 32'd0);
      check("abort_flags", 32'({co4, ovf4, busy4, done4}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done4), 32'd0);
      end
      rst_n  = 1'b1;
      last_s = '0;
      v.a = 16'h1234; v.b = 16'h1111; v.ci = 1'b0; v.sub = 1'b0;
      v.exp = model(16'h1234, 16'h1111, 1'b0, 1'b0);
      run_op(v);

      // Random back-to-back operations on the SLICE=4 instance.
      @(negedge clk);
      for (int n = 0; n < 10000; n++) begin
         drive_rand(r);
         exp4.push_back(r);
         @(posedge clk); #1;
         start = 1'b0;
         k = 0;
         do begin @(negedge clk); k++; end while (!done4 && k < 20);
         if (!done4) begin
            fail("rand4_timeout");
            break;
         end
      end
      start = 1'b0;
      @(negedge clk);

      // Random operations compared across SLICE = 4, 1 and 16.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp4.delete(); exp1.delete(); exp16.delete();
      chk_all = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 800; n++) begin
         drive_rand(r);
         exp4.push_back(r);
         exp1.push_back(r);
         exp16.push_back(r);
         @(posedge clk); #1;
         start = 1'b0;
         k = 0;
         do begin @(negedge clk); k++; end while (!done1 && k < 40);
         if (!done1) begin
            fail("rand1_timeout");
            break;
         end
         check("all_idle", 32'({busy4, busy1, busy16}), 32'd0);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      check("sb4_drain", 32'(exp4.size()), 32'd0);
      check("sb1_drain", 32'(exp1.size()), 32'd0);
      check("sb16_drain", 32'(exp16.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
